// File: rtl/cbd_vector_sampler.sv
// Centered-binomial sampler: streams 64-bit source words and packs 16 coefficients (4 bits each) per output word.
// Define SAMPLER_TWOS_COMP_EN to emit two's-complement coefficients instead of sign-magnitude.
module cbd_vector_sampler #(
    parameter int MU = 8,
    parameter int L  = 3,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rd_en,
    output logic [AW-1:0] rd_address,
    input  logic [63:0]   data_in,
    output logic [63:0]   sample_pack,
    output logic [AW-1:0] wt_address,
    output logic          wen,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int            HALF     = MU / 2;
    localparam int            GRP_BITS = 8 * MU;
    localparam logic [AW-1:0] LAST_RD  = AW'(4 * MU * L - 1);
    localparam logic [AW-1:0] LAST_WR  = AW'(16 * L - 1);

    if (!(MU == 6 || MU == 8 || MU == 10)) begin : g_bad_mu
        $error("cbd_vector_sampler: MU must be 6, 8 or 10");
    end
    if (L < 1 || L > 4) begin : g_bad_l
        $error("cbd_vector_sampler: L must be in 1..4");
    end

    function automatic logic [2:0] pop5(input logic [4:0] v);
        logic [2:0] c;
        c = '0;
        for (int unsigned k = 0; k < 5; k++) c = c + {2'b00, v[k]};
        return c;
    endfunction

    function automatic logic [3:0] enc(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] d;
        d = {1'b0, a} - {1'b0, b};
`ifdef SAMPLER_TWOS_COMP_EN
        return d;
`else
        if (a >= b) return d;
        return {1'b1, b - a};
`endif
    endfunction

    logic [1:0]    r_state;
    logic [191:0]  r_buf;
    logic [7:0]    r_cnt;
    logic          r_valid;
    logic          r_half;
    logic [31:0]   r_lo;
    logic [AW-1:0] r_rd_addr;
    logic [AW-1:0] r_wt_addr;
    logic [63:0]   r_sample;
    logic          r_wen;

    logic          w_active;
    logic          w_cons;
    logic          w_issue;
    logic [7:0]    w_cnt_base;
    logic [7:0]    w_cnt_next;
    logic [191:0]  w_shifted;
    logic [191:0]  w_buf_next;
    logic [31:0]   w_grp;

    // Buffer keeps unconsumed stream bits LSB-first; a group is taken from the bottom before the
    // arriving word is appended, and reads are throttled on the post-update fill level.
    always_comb begin
        w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
        w_cons     = w_active && (r_cnt >= 8'(GRP_BITS));
        w_shifted  = w_cons ? (r_buf >> GRP_BITS) : r_buf;
        w_cnt_base = w_cons ? (r_cnt - 8'(GRP_BITS)) : r_cnt;
        w_buf_next = w_shifted;
        w_cnt_next = w_cnt_base;
        if (r_valid) begin
            w_buf_next = w_shifted | ({128'd0, data_in} << w_cnt_base);
            w_cnt_next = w_cnt_base + 8'd64;
        end
        w_issue = (r_state == S_RUN) && (w_cnt_next <= 8'd128);
    end

    always_comb begin
        w_grp = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            w_grp[4*j +: 4] = enc(pop5(5'(r_buf[j*MU +: HALF])),
                                  pop5(5'(r_buf[j*MU+HALF +: HALF])));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_half    <= 1'b0;
            r_lo      <= '0;
            r_rd_addr <= '0;
            r_wt_addr <= '0;
            r_sample  <= '0;
            r_wen     <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_rd_addr <= '0;
                        r_wt_addr <= '0;
                        r_buf     <= '0;
                        r_cnt     <= '0;
                        r_valid   <= 1'b0;
                        r_half    <= 1'b0;
                    end
                end
                S_RUN:   if (w_issue && r_rd_addr == LAST_RD) r_state <= S_DRAIN;
                S_DRAIN: if (r_wen && r_wt_addr == LAST_WR) r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
            if (w_active) begin
                r_buf   <= w_buf_next;
                r_cnt   <= w_cnt_next;
                r_valid <= w_issue;
            end
            if (w_issue) r_rd_addr <= r_rd_addr + 1'b1;
            if (r_wen)   r_wt_addr <= r_wt_addr + 1'b1;
            if (w_cons) begin
                if (!r_half) begin
                    r_lo   <= w_grp;
                    r_half <= 1'b1;
                end else begin
                    r_sample <= {w_grp, r_lo};
                    r_wen    <= 1'b1;
                    r_half   <= 1'b0;
                end
            end
        end
    end

    assign rd_en       = w_issue;
    assign rd_address  = r_rd_addr;
    assign sample_pack = r_sample;
    assign wt_address  = r_wt_addr;
    assign wen         = r_wen;
    assign busy        = w_active;
    assign done        = (r_state == S_DONE);

endmodule
